round_trigger_gen: RTL and testbench

- Downstream consumer of the AES core's load/busy handshake. Produces the round-aligned trigger on the 40-pin GPIO header (trigger_out) in place of a constant-high tie-off.
- Tracks AES round progress from busy, matches a programmable round, and emits a delayed pulse of programmable width.
- Runs in the crypto clock domain. Config inputs come from the register block, already held stable in that domain.

---
 rtl/round_trig_pkg.sv | 15 +
 rtl/round_trigger_gen_if.sv | 7 +
 rtl/round_trig_pulse.sv | 62 ++++++
 rtl/round_trigger_gen.sv | 124 ++++++++++++
 tb/tb_round_trigger_gen.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/round_trig_pkg.sv
// round_trig_pkg: shared state encodings and default constants for the round trigger generator.
package round_trig_pkg;
    localparam int DEF_ROUND_CYCLES = 1;
    localparam int DEF_MAX_ROUNDS   = 14;
    localparam int DEF_DELAY_WIDTH  = 8;
    localparam int DEF_LEN_WIDTH    = 4;
    localparam int TS_W             = 16;

    typedef enum logic [1:0] {IDLE, WAIT, RUN} trk_state_t;
    typedef enum logic [1:0] {P_IDLE, P_DELAY, P_PULSE} pulse_state_t;

    function automatic int max_int(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/round_trigger_gen_if.sv
// round_trigger_gen_if: AES core load/busy handshake as seen by the round trigger generator.
interface round_trigger_gen_if;
    logic I_load;
    logic I_busy;
    modport master (output I_load, output I_busy);
    modport slave  (input I_load, input I_busy);
endinterface

// File: rtl/round_trig_pulse.sv
// round_trig_pulse: delay/pulse FSM turning a round match into a delayed trigger pulse.
module round_trig_pulse
    import round_trig_pkg::*;
#(
    parameter int pDELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int pLEN_WIDTH   = DEF_LEN_WIDTH
) (
    input  logic                    crypto_clk,
    input  logic                    reset_i,
    input  logic                    match,
    input  logic [pDELAY_WIDTH-1:0] delay,
    input  logic [pLEN_WIDTH-1:0]   pulse_len,
    output logic                    trigger,
    output logic                    drop
);
    localparam int CW = max_int(pDELAY_WIDTH, pLEN_WIDTH);

    pulse_state_t   state, state_n;
    logic [CW-1:0]  cnt, cnt_n, len_m1, dly_m1;
    logic           free;

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            state <= P_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // The last pulse cycle counts as free so back-to-back matches chain without a gap.
    always_comb begin
        len_m1  = pulse_len == '0 ? '0 : CW'(pulse_len) - CW'(1);
        dly_m1  = CW'(delay) - CW'(1);
        free    = state == P_IDLE || (state == P_PULSE && cnt == '0);
        drop    = match && !free;
        state_n = state;
        cnt_n   = cnt;
        if (match && free) begin
            if (delay == '0) begin
                state_n = P_PULSE;
                cnt_n   = len_m1;
            end else begin
                state_n = P_DELAY;
                cnt_n   = dly_m1;
            end
        end else if (state == P_DELAY) begin
            if (cnt == '0) begin
                state_n = P_PULSE;
                cnt_n   = len_m1;
            end else begin
                cnt_n   = cnt - CW'(1);
            end
        end else if (state == P_PULSE) begin
            if (cnt == '0) state_n = P_IDLE;
            else cnt_n = cnt - CW'(1);
        end
    end

    assign trigger = state == P_PULSE;
endmodule

// File: rtl/round_trigger_gen.sv
// round_trigger_gen: tracks AES rounds from busy and fires a programmable round-aligned trigger.
// Optional O_timestamp (load-to-trigger cycle count) when ROUND_TRIG_TIMESTAMP_EN is defined.
module round_trigger_gen
    import round_trig_pkg::*;
#(
    parameter int pROUND_CYCLES = DEF_ROUND_CYCLES,
    parameter int pMAX_ROUNDS   = DEF_MAX_ROUNDS,
    parameter int pDELAY_WIDTH  = DEF_DELAY_WIDTH,
    parameter int pLEN_WIDTH    = DEF_LEN_WIDTH
) (
    input  logic                    crypto_clk,
    input  logic                    reset_i,
    round_trigger_gen_if.slave      core,
    input  logic                    I_arm,
    input  logic                    I_mode,
    input  logic [3:0]              I_round_sel,
    input  logic [pDELAY_WIDTH-1:0] I_delay,
    input  logic [pLEN_WIDTH-1:0]   I_pulse_len,
    output logic                    O_trigger,
    output logic                    O_armed,
    output logic [3:0]              O_round,
`ifdef ROUND_TRIG_TIMESTAMP_EN
    output logic [TS_W-1:0]         O_timestamp,
`endif
    output logic                    O_missed
);
    localparam int RW = $clog2(pMAX_ROUNDS + 1);
    localparam int SW = pROUND_CYCLES > 1 ? $clog2(pROUND_CYCLES) : 1;
    localparam logic [RW-1:0] RMAX = RW'(pMAX_ROUNDS);
    localparam logic [SW-1:0] SLAST = SW'(pROUND_CYCLES - 1);

    trk_state_t              state, state_n;
    logic [RW-1:0]           round;
    logic [SW-1:0]           sub_cnt;
    logic                    mode_l;
    logic [3:0]              round_sel_l;
    logic [pDELAY_WIDTH-1:0] delay_l;
    logic [pLEN_WIDTH-1:0]   len_l;
    logic                    load_ok, busy_step, round_start, match, drop;

    // WAIT's first busy cycle doubles as the first RUN cycle, so it steps the counters too.
    always_comb begin
        load_ok     = state == IDLE && O_armed && core.I_load;
        busy_step   = core.I_busy && state != IDLE;
        round_start = busy_step && sub_cnt == '0;
        match       = round_start && (mode_l || 4'(round) == round_sel_l);
        state_n     = state;
        if (load_ok) state_n = WAIT;
        else if (state == WAIT && core.I_busy) state_n = RUN;
        else if (state == RUN && !core.I_busy) state_n = IDLE;
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            O_armed     <= 1'b0;
            O_missed    <= 1'b0;
            round       <= '0;
            sub_cnt     <= '0;
            mode_l      <= 1'b0;
            round_sel_l <= '0;
            delay_l     <= '0;
            len_l       <= '0;
        end else begin
            if (state == IDLE && I_arm) O_armed <= 1'b1;
            else if (state == RUN && !core.I_busy) O_armed <= 1'b0;
            if (load_ok) begin
                mode_l      <= I_mode;
                round_sel_l <= I_round_sel;
                delay_l     <= I_delay;
                len_l       <= I_pulse_len;
                round       <= '0;
                sub_cnt     <= '0;
                O_missed    <= 1'b0;
            end else begin
                if (busy_step) begin
                    sub_cnt <= sub_cnt == SLAST ? '0 : sub_cnt + SW'(1);
                    if (sub_cnt == SLAST && round != RMAX) round <= round + RW'(1);
                end
                if (drop) O_missed <= 1'b1;
            end
        end
    end

    assign O_round = 4'(round);

    round_trig_pulse #(
        .pDELAY_WIDTH (pDELAY_WIDTH),
        .pLEN_WIDTH   (pLEN_WIDTH)
    ) u_pulse (
        .crypto_clk (crypto_clk),
        .reset_i    (reset_i),
        .match      (match),
        .delay      (delay_l),
        .pulse_len  (len_l),
        .trigger    (O_trigger),
        .drop       (drop)
    );

`ifdef ROUND_TRIG_TIMESTAMP_EN
    logic ts_frozen, trig_q;

    always_ff @(posedge crypto_clk or posedge reset_i) begin
        if (reset_i) begin
            O_timestamp <= '0;
            ts_frozen   <= 1'b0;
            trig_q      <= 1'b0;
        end else begin
            trig_q <= O_trigger;
            if (load_ok) begin
                O_timestamp <= '0;
                ts_frozen   <= 1'b0;
            end else begin
                if (!ts_frozen && O_timestamp != '1) O_timestamp <= O_timestamp + TS_W'(1);
                if (O_trigger && !trig_q) ts_frozen <= 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_round_trigger_gen.sv
// tb_round_trigger_gen: directed vector table plus hand-written multi-cycle sequences.
module tb_round_trigger_gen;
    import round_trig_pkg::*;

    logic       crypto_clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       I_arm = 1'b0, I_mode = 1'b0;
    logic [3:0] I_round_sel = '0;
    logic [7:0] I_delay = '0;
    logic [3:0] I_pulse_len = '0;
    logic       O_trigger, O_armed, O_missed;
    logic [3:0] O_round;
`ifdef ROUND_TRIG_TIMESTAMP_EN
    logic [15:0] O_timestamp;
`endif

    round_trigger_gen_if core ();

    round_trigger_gen dut (
        .crypto_clk  (crypto_clk),
        .reset_i     (reset_i),
        .core        (core),
        .I_arm       (I_arm),
        .I_mode      (I_mode),
        .I_round_sel (I_round_sel),
        .I_delay     (I_delay),
        .I_pulse_len (I_pulse_len),
        .O_trigger   (O_trigger),
        .O_armed     (O_armed),
        .O_round     (O_round),
`ifdef ROUND_TRIG_TIMESTAMP_EN
        .O_timestamp (O_timestamp),
`endif
        .O_missed    (O_missed)
    );

    always #5 crypto_clk = ~crypto_clk;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        bit arm, load, busy;
        bit trig, armed;
        int round;
        bit missed;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic start(input bit mode, input int sel, input int dly, input int len);
        I_mode = mode;
        I_round_sel = 4'(sel);
        I_delay = 8'(dly);
        I_pulse_len = 4'(len);
        I_arm = 1'b1;
        @(negedge crypto_clk);
        I_arm = 1'b0;
        core.I_load = 1'b1;
        @(negedge crypto_clk);
        core.I_load = 1'b0;
    endtask

    initial begin
        int hi;
        core.I_load = 1'b0;
        core.I_busy = 1'b0;

        // Round 3 of 10, immediate 2-cycle pulse; then loads that must be ignored.
        tv.push_back('{1, 0, 0, 0, 1, 0, 0});
        tv.push_back('{0, 1, 0, 0, 1, 0, 0});
        for (int k = 0; k < 10; k++) tv.push_back('{0, 0, 1, (k == 3 || k == 4), 1, k + 1, 0});
        tv.push_back('{0, 0, 0, 0, 0, 10, 0});
        tv.push_back('{0, 1, 0, 0, 0, 10, 0});
        tv.push_back('{0, 0, 1, 0, 0, 10, 0});
        tv.push_back('{0, 0, 1, 0, 0, 10, 0});
        tv.push_back('{1, 1, 0, 0, 1, 10, 0});
        tv.push_back('{0, 0, 1, 0, 1, 10, 0});
        tv.push_back('{0, 0, 0, 0, 1, 10, 0});

        repeat (2) @(negedge crypto_clk);
        check("rst_trig", O_trigger, 0);
        check("rst_armed", O_armed, 0);
        check("rst_round", O_round, 0);
        check("rst_missed", O_missed, 0);
        reset_i = 1'b0;
        I_round_sel = 4'd3;
        I_pulse_len = 4'd2;

        foreach (tv[i]) begin
            I_arm = tv[i].arm;
            core.I_load = tv[i].load;
            core.I_busy = tv[i].busy;
            @(negedge crypto_clk);
            check($sformatf("vec%0d_trig", i), O_trigger, tv[i].trig);
            check($sformatf("vec%0d_armed", i), O_armed, tv[i].armed);
            check($sformatf("vec%0d_round", i), O_round, tv[i].round);
            check($sformatf("vec%0d_missed", i), O_missed, tv[i].missed);
        end
        I_arm = 1'b0;
        core.I_load = 1'b0;
        core.I_busy = 1'b0;
`ifdef ROUND_TRIG_TIMESTAMP_EN
        check("ts_load_to_trig", O_timestamp, 5);
`endif

        // Every-round mode, 1-cycle pulses: all 10 matches chain.
        start(1, 0, 0, 1);
        hi = 0;
        for (int k = 0; k < 11; k++) begin
            core.I_busy = k < 10;
            @(negedge crypto_clk);
            hi += int'(O_trigger);
        end
        check("m1_len1_high", hi, 10);
        check("m1_len1_missed", O_missed, 0);
        check("m1_len1_armed", O_armed, 0);

        // Every-round mode, 2-cycle pulses: every second match is dropped.
        start(1, 0, 0, 2);
        hi = 0;
        for (int k = 0; k < 11; k++) begin
            core.I_busy = k < 10;
            @(negedge crypto_clk);
            hi += int'(O_trigger);
        end
        check("m1_len2_high", hi, 10);
        check("m1_len2_missed", O_missed, 1);

        // Selected round beyond the executed rounds: no trigger.
        start(0, 12, 0, 1);
        check("sel12_missed_clr", O_missed, 0);
        hi = 0;
        for (int k = 0; k < 11; k++) begin
            core.I_busy = k < 10;
            @(negedge crypto_clk);
            hi += int'(O_trigger);
            if (k == 8) check("sel12_last_round", O_round, 9);
        end
        check("sel12_no_trig", hi, 0);

        // Second load while running is ignored; match on round 5 still lands.
        start(0, 5, 0, 1);
        for (int k = 0; k < 9; k++) begin
            core.I_busy = k < 8;
            core.I_load = k == 3;
            @(negedge crypto_clk);
            check($sformatf("reload_trig%0d", k), O_trigger, int'(k == 5));
            if (k == 3) begin
                check("reload_round", O_round, 4);
                check("reload_armed", O_armed, 1);
            end
        end
        core.I_load = 1'b0;

        // Delay 5, length 3, busy drops 2 cycles after the match on round 2.
        start(0, 2, 5, 3);
        for (int c = 0; c < 14; c++) begin
            core.I_busy = c < 4;
            @(negedge crypto_clk);
            check($sformatf("delay_trig%0d", c + 1), O_trigger, int'(c + 1 >= 8 && c + 1 <= 10));
        end
        check("delay_armed", O_armed, 0);

        // Asynchronous reset in the middle of a pulse.
        start(0, 0, 0, 8);
        core.I_busy = 1'b1;
        @(negedge crypto_clk);
        core.I_busy = 1'b0;
        repeat (2) @(negedge crypto_clk);
        check("pre_rst_trig", O_trigger, 1);
        #1 reset_i = 1'b1;
        #1;
        check("async_rst_trig", O_trigger, 0);
        check("async_rst_armed", O_armed, 0);
        check("async_rst_round", O_round, 0);
        check("async_rst_missed", O_missed, 0);
`ifdef ROUND_TRIG_TIMESTAMP_EN
        check("async_rst_ts", O_timestamp, 0);
`endif
        @(negedge crypto_clk);
        reset_i = 1'b0;
        repeat (2) @(negedge crypto_clk);
        check("post_rst_trig", O_trigger, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
